// File: rtl/fft_stage_feeder_pkg.sv
// Shared types for the FFT stage feeder: controller state encoding.
package fft_stage_feeder_pkg;

   // FILL collects one frame of samples, ISSUE streams butterfly operand sets.
   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

endpackage

// File: rtl/fft_dual_read_buf.sv
// Stage sample buffer: DEPTH x DW register array, one write port and two
// registered read ports that hold their data while rd_en is low.
module fft_dual_read_buf #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [DW-1:0] rd_data_a,
   output logic [DW-1:0] rd_data_b
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_a_q;
   logic [DW-1:0] rd_b_q;

   // Sample write port.
   // NOTE: the storage array is deliberately not reset; every entry of a frame is
   // written before it is read, and a reset here would only add fan-out.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Registered read ports; outputs hold between reads.
   // NOTE: state is updated with non-blocking assignments so all flops see the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else if (rd_en) begin
         rd_a_q <= mem_q[rd_addr_a];
         rd_b_q <= mem_q[rd_addr_b];
      end
   end

   assign rd_data_a = rd_a_q;
   assign rd_data_b = rd_b_q;

endmodule

// File: rtl/fft_stage_feeder.sv
// Radix-2 DIT stage feeder: buffers N bit-reversed samples, then issues N/2
// butterfly operand sets {xa, xb, w, m_out}, one set every second clock.
module fft_stage_feeder
   import fft_stage_feeder_pkg::*;
#(
   parameter int N      = 8,
   parameter int LOG_N  = 3,
   parameter int X_WDTH = 16,
   parameter int STAGE  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2*X_WDTH-1:0]   in_x,
   input  logic                  in_nd,
   output logic                  in_rdy,
   output logic [LOG_N-2:0]      tw_addr,
   input  logic [2*X_WDTH-1:0]   tw_data,
   output logic [2*X_WDTH-1:0]   xa,
   output logic [2*X_WDTH-1:0]   xb,
   output logic [2*X_WDTH-1:0]   w,
   output logic [LOG_N-1:0]      m_out,
   output logic                  x_nd,
   output logic                  busy,
   output logic                  overflow
);

   localparam int HALF = 1 << STAGE;
   // Bit STAGE of ia is always zero, so ib is ia with that bit set.
   localparam logic [LOG_N-1:0] HALF_BIT  = LOG_N'(HALF);
   localparam logic [LOG_N-1:0] J_MASK    = LOG_N'(HALF - 1);
   localparam logic [LOG_N-2:0] J_MASK_TW = (LOG_N-1)'(HALF - 1);
   localparam int               TW_SHIFT  = LOG_N - 1 - STAGE;

   state_t           state_q,    state_d;
   logic [LOG_N-1:0] wr_cnt_q,   wr_cnt_d;
   logic [LOG_N-2:0] k_q,        k_d;
   logic             phase_q,    phase_d;
   logic             x_nd_q,     x_nd_d;
   logic [LOG_N-1:0] m_out_q,    m_out_d;
   logic             overflow_q, overflow_d;

   logic             wr_en;
   logic             rd_en;
   logic [LOG_N-1:0] k_ext;
   logic [LOG_N-1:0] ia;
   logic [LOG_N-1:0] ib;
   logic [LOG_N-2:0] tw_idx;

   // Butterfly indices for the current k: ia = (k/half)*2*half + (k mod half).
   assign k_ext  = {1'b0, k_q};
   assign ia     = ((k_ext >> STAGE) << (STAGE + 1)) | (k_ext & J_MASK);
   assign ib     = ia | HALF_BIT;
   assign tw_idx = (k_q & J_MASK_TW) << TW_SHIFT;

   assign wr_en  = in_nd && (state_q == ST_FILL);
   // Reads are launched on the first cycle of each two-cycle issue slot.
   assign rd_en  = (state_q == ST_ISSUE) && !phase_q;

   // Next-state, counters, issue strobe and sticky overflow.
   // NOTE: every _d gets a default first so no path through this block can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      k_d        = k_q;
      phase_d    = phase_q;
      x_nd_d     = 1'b0;
      m_out_d    = m_out_q;
      overflow_d = overflow_q | (in_nd && (state_q != ST_FILL));

      unique case (state_q)
         ST_FILL: begin
            if (in_nd) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == '1) begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            phase_d = !phase_q;
            if (!phase_q) begin
               x_nd_d  = 1'b1;
               m_out_d = ia;
            end else begin
               k_d = k_q + 1'b1;
               if (k_q == '1) begin
                  state_d = ST_FILL;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_FILL;
         wr_cnt_q   <= '0;
         k_q        <= '0;
         phase_q    <= 1'b0;
         x_nd_q     <= 1'b0;
         m_out_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         k_q        <= k_d;
         phase_q    <= phase_d;
         x_nd_q     <= x_nd_d;
         m_out_q    <= m_out_d;
         overflow_q <= overflow_d;
      end
   end

   fft_dual_read_buf #(
      .DEPTH (N),
      .AW    (LOG_N),
      .DW    (2*X_WDTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_cnt_q),
      .wr_data   (in_x),
      .rd_en     (rd_en),
      .rd_addr_a (ia),
      .rd_addr_b (ib),
      .rd_data_a (xa),
      .rd_data_b (xb)
   );

   // The ROM samples tw_addr on the read cycle; its data lines up with x_nd.
   assign tw_addr  = tw_idx;
   assign w        = tw_data;
   assign m_out    = m_out_q;
   assign x_nd     = x_nd_q;
   assign in_rdy   = (state_q == ST_FILL);
   assign busy     = (state_q == ST_ISSUE);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_fft_stage_feeder.sv
// Bench: three feeders (STAGE 0,1,2, N=8) share one input stream; a frame-level
// model predicts every operand set, twiddle address and status flag per cycle.
module tb_fft_stage_feeder;

   localparam int N   = 8;
   localparam int NST = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_x;
   logic        in_nd;

   logic        in_rdy_s   [NST];
   logic [1:0]  tw_addr_s  [NST];
   logic [31:0] tw_data_s  [NST];
   logic [31:0] xa_s       [NST];
   logic [31:0] xb_s       [NST];
   logic [31:0] w_s        [NST];
   logic [2:0]  m_s        [NST];
   logic        x_nd_s     [NST];
   logic        busy_s     [NST];
   logic        ovf_s      [NST];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Twiddle ROM contents W = exp(-j*2*pi*a/8), Q1.14 {re, im}.
   function automatic logic [31:0] rom_val(input int a);
      case (a)
         0:       return 32'h4000_0000;
         1:       return 32'h2D41_D2BF;
         2:       return 32'h0000_C000;
         default: return 32'hD2BF_D2BF;
      endcase
   endfunction

   for (genvar g = 0; g < NST; g++) begin : g_dut
      fft_stage_feeder #(
         .N      (N),
         .LOG_N  (3),
         .X_WDTH (16),
         .STAGE  (g)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_x     (in_x),
         .in_nd    (in_nd),
         .in_rdy   (in_rdy_s[g]),
         .tw_addr  (tw_addr_s[g]),
         .tw_data  (tw_data_s[g]),
         .xa       (xa_s[g]),
         .xb       (xb_s[g]),
         .w        (w_s[g]),
         .m_out    (m_s[g]),
         .x_nd     (x_nd_s[g]),
         .busy     (busy_s[g]),
         .overflow (ovf_s[g])
      );

      // External synchronous ROM, one clock of latency.
      always_ff @(posedge clk) tw_data_s[g] <= rom_val(int'(tw_addr_s[g]));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          mdl_live  = 1'b0;
   bit          mdl_fill  = 1'b1;
   bit          mdl_ovf   = 1'b0;
   bit          after_rst = 1'b0;
   int          ic        = 0;       // cycles since the frame entered issue
   int          frames_done = 0;
   logic [31:0] q_samp [$];
   logic [31:0] frame  [N];
   logic [31:0] last_xa [NST];
   logic [31:0] last_xb [NST];
   int          last_m  [NST];
   bit          have_x  [NST];
   bit          prev_xnd[NST];

   // Compare every output against the model mid-cycle, then advance the model.
   always @(negedge clk) begin
      if (mdl_live) begin
         for (int s = 0; s < NST; s++) begin
            int half, k, j, ia, ib, t;
            bit exp_xnd;
            half    = 1 << s;
            exp_xnd = !mdl_fill && (ic % 2 == 1);
            check($sformatf("in_rdy_s%0d", s), 32'(in_rdy_s[s]), 32'(mdl_fill));
            check($sformatf("busy_s%0d", s), 32'(busy_s[s]), 32'(!mdl_fill));
            check($sformatf("x_nd_s%0d", s), 32'(x_nd_s[s]), 32'(exp_xnd));
            check($sformatf("overflow_s%0d", s), 32'(ovf_s[s]), 32'(mdl_ovf));
            check($sformatf("xnd_consec_s%0d", s), 32'(prev_xnd[s] & x_nd_s[s]), 32'd0);
            prev_xnd[s] = x_nd_s[s];
            if (after_rst) check($sformatf("tw_addr_rst_s%0d", s), 32'(tw_addr_s[s]), 32'd0);
            k  = ic / 2;
            j  = k % half;
            ia = (k / half) * 2 * half + j;
            ib = ia + half;
            t  = j * (4 / half);
            if (!mdl_fill && ic % 2 == 0)
               check($sformatf("tw_addr_s%0d", s), 32'(tw_addr_s[s]), 32'(t));
            if (exp_xnd) begin
               check($sformatf("xa_s%0d", s), xa_s[s], frame[ia]);
               check($sformatf("xb_s%0d", s), xb_s[s], frame[ib]);
               check($sformatf("m_out_s%0d", s), 32'(m_s[s]), 32'(ia));
               check($sformatf("w_s%0d", s), w_s[s], rom_val(t));
               last_xa[s] = frame[ia];
               last_xb[s] = frame[ib];
               last_m[s]  = ia;
               have_x[s]  = 1'b1;
            end else begin
               check($sformatf("m_hold_s%0d", s), 32'(m_s[s]), 32'(last_m[s]));
               if (have_x[s]) begin
                  check($sformatf("xa_hold_s%0d", s), xa_s[s], last_xa[s]);
                  check($sformatf("xb_hold_s%0d", s), xb_s[s], last_xb[s]);
               end
            end
         end
      end

      if (!rst_n) begin
         mdl_live  = 1'b1;
         mdl_fill  = 1'b1;
         mdl_ovf   = 1'b0;
         after_rst = 1'b1;
         ic        = 0;
         q_samp.delete();
         for (int s = 0; s < NST; s++) begin
            last_m[s]   = 0;
            have_x[s]   = 1'b0;
            prev_xnd[s] = 1'b0;
         end
      end else if (mdl_live) begin
         after_rst = 1'b0;
         if (mdl_fill) begin
            if (in_nd) begin
               q_samp.push_back(in_x);
               if (q_samp.size() == N) begin
                  for (int i = 0; i < N; i++) frame[i] = q_samp[i];
                  q_samp.delete();
                  mdl_fill = 1'b0;
                  ic       = 0;
               end
            end
         end else begin
            if (in_nd) mdl_ovf = 1'b1;
            ic++;
            if (ic == N) begin
               mdl_fill = 1'b1;
               frames_done++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic nd, input logic [31:0] x);
      @(posedge clk);
      #1;
      in_nd = nd;
      in_x  = x;
   endtask

   initial begin
      int base;
      int budget;
      rst_n = 1'b0;
      in_nd = 1'b0;
      in_x  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed frame: re = 0..7, im = 0.
      for (int i = 0; i < N; i++) drive(1'b1, {16'(i), 16'h0000});
      repeat (12) drive(1'b0, '0);

      // in_nd held high across two frames: samples during issue are dropped.
      for (int i = 0; i < 3*N; i++) drive(1'b1, {16'(100 + i), 16'h0000});
      repeat (12) drive(1'b0, '0);

      // Reset during issue at T+3; that frame must never appear.
      for (int i = 0; i < N; i++) drive(1'b1, {16'(200 + i), 16'h00AA});
      repeat (3) drive(1'b0, '0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < N; i++) drive(1'b1, {16'(300 + i), 16'h0055});
      repeat (12) drive(1'b0, '0);

      // Random gaps and data until 100 more frames have been issued.
      base   = frames_done;
      budget = 0;
      while (frames_done < base + 100 && budget < 20000) begin
         drive(($urandom_range(0, 3) != 0), $urandom);
         budget++;
      end
      check("random_frames", 32'(frames_done - base), 32'd100);
      repeat (12) drive(1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
